tx_output_buffer: RTL and testbench
===================================

# tx_output_buffer

Byte-wide synchronous FIFO that sits between the packet-assembly logic and the transmit serializer in the output-buffer subsystem. The upstream side stores one byte per strobe. The downstream transmitter pulls bytes one at a time. The block reports occupancy, full/empty status and sticky overflow/underflow errors, and a synchronous clear flushes it between packets.

## Interface
- DATA_WIDTH, default 8: width of each stored word.
- DEPTH, default 64: number of entries; must be a power of 2.
- ADDR_BITS, default 6: log2(DEPTH); sets the pointer width. Occupancy is ADDR_BITS+1 bits wide.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: empties the buffer and clears the error flags.
- store_tx_data  in  1  write strobe; one word per cycle while high.
- tx_data  in  DATA_WIDTH  write data, sampled on the edge where store_tx_data is high.
- get_tx_packet_data  in  1  read strobe; one word per cycle while high.
- tx_packet_data  out  DATA_WIDTH  registered read data.
- buffer_occupancy  out  ADDR_BITS+1  number of words currently stored, 0..DEPTH.
- full  out  1  high when buffer_occupancy == DEPTH.
- empty  out  1  high when buffer_occupancy == 0.
- overflow_err  out  1  sticky; set by a rejected write.
- underflow_err  out  1  sticky; set by a rejected read.

## Operation
- Storage is a DEPTH x DATA_WIDTH register array. It is not reset, and its contents are don't-care until written.
- Pointers:
  - write pointer and read pointer, each ADDR_BITS wide;
  - each wraps from DEPTH-1 to 0 with natural modulo-DEPTH arithmetic;
  - buffer_occupancy is a separate registered counter.
- Accepted write: store_tx_data high and (not full, or get_tx_packet_data accepted in the same cycle).
  - mem[wptr] <= tx_data; wptr increments.
- Accepted read: get_tx_packet_data high and not empty.
  - tx_packet_data <= mem[rptr]; rptr increments.
- Occupancy update per cycle:
  - +1 for an accepted write alone;
  - -1 for an accepted read alone;
  - unchanged when both are accepted or neither is.
- Rejected write (full, no accepted read): data dropped, pointers unchanged, overflow_err <= 1.
- Rejected read (empty): tx_packet_data holds its value, rptr unchanged, underflow_err <= 1.
- Simultaneous events:
  - Full, with write and read together: both accepted. The read returns the oldest word and the new word takes the freed slot. Occupancy stays at DEPTH and no error is raised.
  - Empty, with write and read together: the write is accepted and the read is rejected (no fall-through). Occupancy becomes 1 and underflow_err is set.
- Error flags stay set until clear or reset.
- clear has priority over store and get in the same cycle:
  - wptr, rptr and occupancy go to 0;
  - tx_packet_data goes to 0;
  - both error flags go to 0;
  - any write or read requested in that cycle is ignored.
- full and empty are decoded from the registered occupancy. There is no combinational path from the strobes to any output.

## Timing
- Reset (n_rst low, asynchronous) sets:
  - pointers and occupancy to 0;
  - tx_packet_data to 0;
  - empty to 1, full to 0;
  - overflow_err and underflow_err to 0.
- Reset takes effect immediately, including in the middle of a burst. Anything written before reset is lost.
- Write latency: a word stored at edge k is readable by a get in cycle k+1. Occupancy, full and empty reflect the write after edge k.
- Read latency: 1 cycle. For a get accepted at edge k, tx_packet_data is valid after edge k and holds until the next accepted read, a clear or a reset.
- Throughput: one write and one read per cycle, sustained.
- Error flags assert on the edge that ends the offending cycle.

## Test plan
- Reset then idle: empty=1, full=0, occupancy=0, tx_packet_data=0x00, both errors 0.
- Store 0xA1, 0xB2, 0xC3 on consecutive cycles, then get three times. Expect:
  - tx_packet_data = 0xA1, 0xB2, 0xC3 on the edges of the get cycles;
  - occupancy 3 -> 0;
  - empty=1 at the end.
- Store 64 words (0x00..0x3F): full=1 and occupancy=64. Then:
  - store 0xFF once: word dropped, overflow_err=1;
  - read all 64: returns 0x00..0x3F in order, no 0xFF.
- Wrap-around: repeatedly store 40 words, read 40, for 3 rounds. Expect in-order data every round and occupancy back at 0 after each round.
- Simultaneous events:
  - at full, assert store and get together for 10 cycles: occupancy stays 64, no overflow_err, FIFO order preserved;
  - at empty, store 0x5A and get together: underflow_err=1, occupancy=1, a following get returns 0x5A.
- Clear and reset:
  - with 5 words stored and both errors set, assert clear together with a store: occupancy=0, empty=1, errors 0, tx_packet_data=0x00, the stored word is ignored;
  - assert n_rst low in the middle of a burst: all outputs go to reset values immediately.

Source files
------------

// File: rtl/tx_output_buffer.sv
// Byte-wide synchronous FIFO between packet assembly and the transmit serializer.
// Registered read data, registered occupancy counter, sticky overflow/underflow flags.
module tx_output_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  store_tx_data,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  get_tx_packet_data,
  output logic [DATA_WIDTH-1:0] tx_packet_data,
  output logic [ADDR_BITS:0]    buffer_occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam logic [ADDR_BITS:0] DEPTH_COUNT = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  wptr_reg;
  logic [ADDR_BITS-1:0]  rptr_reg;
  logic [ADDR_BITS:0]    count_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  rd_ok;
  logic                  wr_ok;

  assign full  = (count_reg == DEPTH_COUNT);
  assign empty = (count_reg == '0);

  // A write into a full buffer is still accepted when a read frees a slot this cycle.
  assign rd_ok = get_tx_packet_data && !empty;
  assign wr_ok = store_tx_data && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) begin
      mem[wptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      rdata_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      rdata_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr_reg <= wptr_reg + ADDR_BITS'(1);
      end
      if (rd_ok) begin
        rdata_reg <= mem[rptr_reg];
        rptr_reg  <= rptr_reg + ADDR_BITS'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + (ADDR_BITS + 1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_BITS + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (store_tx_data && !wr_ok) begin
        overflow_reg <= 1'b1;
      end
      if (get_tx_packet_data && !rd_ok) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign tx_packet_data   = rdata_reg;
  assign buffer_occupancy = count_reg;
  assign overflow_err     = overflow_reg;
  assign underflow_err    = underflow_reg;

endmodule

// File: tb/tb_tx_output_buffer.sv
// Randomized and directed bench for tx_output_buffer, checked against a queue-based FIFO model.
module tb_tx_output_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int AB    = 6;

  logic          clk;
  logic          n_rst;
  logic          clear;
  logic          store_tx_data;
  logic [DW-1:0] tx_data;
  logic          get_tx_packet_data;
  logic [DW-1:0] tx_packet_data;
  logic [AB:0]   buffer_occupancy;
  logic          full;
  logic          empty;
  logic          overflow_err;
  logic          underflow_err;

  int n_checks;
  int n_fail;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_data;
  logic          model_ovf;
  logic          model_unf;

  tx_output_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .clear              (clear),
    .store_tx_data      (store_tx_data),
    .tx_data            (tx_data),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .full               (full),
    .empty              (empty),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_data = '0;
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
  endtask

  // FIFO behaviour from the rules: clear wins, read needs data, write needs room or a same-cycle read.
  task automatic model_step(input logic clr, input logic st, input logic [DW-1:0] d, input logic gt);
    bit rd;
    bit wr;
    if (clr) begin
      model_reset();
      return;
    end
    rd = gt && (model_q.size() > 0);
    wr = st && ((model_q.size() < DEPTH) || rd);
    if (rd) model_data = model_q.pop_front();
    if (wr) model_q.push_back(d);
    if (st && !wr) model_ovf = 1'b1;
    if (gt && !rd) model_unf = 1'b1;
  endtask

  task automatic compare_all();
    check_val("occupancy", 32'(buffer_occupancy), 32'(model_q.size()));
    check_val("full", 32'(full), 32'(model_q.size() == DEPTH));
    check_val("empty", 32'(empty), 32'(model_q.size() == 0));
    check_val("rdata", 32'(tx_packet_data), 32'(model_data));
    check_val("overflow_err", 32'(overflow_err), 32'(model_ovf));
    check_val("underflow_err", 32'(underflow_err), 32'(model_unf));
  endtask

  task automatic do_cycle(input logic clr, input logic st, input logic [DW-1:0] d, input logic gt);
    clear              = clr;
    store_tx_data      = st;
    tx_data            = d;
    get_tx_packet_data = gt;
    @(posedge clk);
    model_step(clr, st, d, gt);
    #1;
    $display("cyc clr=%0b st=%0b d=%02h gt=%0b -> q=%02h occ=%0d ovf=%0b unf=%0b",
             clr, st, d, gt, tx_packet_data, buffer_occupancy, overflow_err, underflow_err);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_occ"}, 32'(buffer_occupancy), 32'd0);
    check_val({tag, "_empty"}, 32'(empty), 32'd1);
    check_val({tag, "_full"}, 32'(full), 32'd0);
    check_val({tag, "_rdata"}, 32'(tx_packet_data), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    check_val({tag, "_unf"}, 32'(underflow_err), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_rst    = 1'b0;
    clear    = 1'b0;
    store_tx_data      = 1'b0;
    tx_data            = '0;
    get_tx_packet_data = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (2) do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_reset_values("reset_idle");

    // Three stores then three gets
    do_cycle(1'b0, 1'b1, 8'hA1, 1'b0);
    do_cycle(1'b0, 1'b1, 8'hB2, 1'b0);
    do_cycle(1'b0, 1'b1, 8'hC3, 1'b0);
    check_val("occ_after_3", 32'(buffer_occupancy), 32'd3);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("get_a1", 32'(tx_packet_data), 32'hA1);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("get_b2", 32'(tx_packet_data), 32'hB2);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("get_c3", 32'(tx_packet_data), 32'hC3);
    check_val("empty_after_3", 32'(empty), 32'd1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 8'(i), 1'b0);
    check_val("full_at_64", 32'(full), 32'd1);
    do_cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    check_val("overflow_set", 32'(overflow_err), 32'd1);
    check_val("occ_still_64", 32'(buffer_occupancy), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_val("drain_order", 32'(tx_packet_data), 32'(i));
    end
    do_cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Wrap-around rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) do_cycle(1'b0, 1'b1, 8'(r * 40 + i + 7), 1'b0);
      for (int i = 0; i < 40; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
      check_val("wrap_occ0", 32'(buffer_occupancy), 32'd0);
    end

    // Simultaneous at full
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
    check_val("full_sim_occ", 32'(buffer_occupancy), 32'd64);
    check_val("full_sim_ovf", 32'(overflow_err), 32'd0);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous at empty
    do_cycle(1'b0, 1'b1, 8'h5A, 1'b1);
    check_val("empty_sim_unf", 32'(underflow_err), 32'd1);
    check_val("empty_sim_occ", 32'(buffer_occupancy), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("empty_sim_5a", 32'(tx_packet_data), 32'h5A);

    // Both errors set with 5 stored, then clear together with a store
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1'b0, 1'b1, 8'(i * 3), 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("pre_clear_occ", 32'(buffer_occupancy), 32'd5);
    do_cycle(1'b1, 1'b1, 8'h77, 1'b0);
    check_reset_values("clear");
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("clear_ignored_store", 32'(underflow_err), 32'd1);
    do_cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // Randomized traffic in phases biased toward filling or draining
    for (int p = 0; p < 12; p++) begin
      int wp;
      wp = (p % 3 == 0) ? 80 : ((p % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 150; i++) begin
        do_cycle(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < wp) ? 1'b1 : 1'b0,
                 8'($urandom()),
                 ($urandom_range(99) < (100 - wp)) ? 1'b1 : 1'b0);
      end
    end

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 8'(8'hE0 + i), (i > 2) ? 1'b1 : 1'b0);
    store_tx_data = 1'b1;
    tx_data       = 8'hEE;
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(posedge clk);
    #1 check_reset_values("reset_held");
    #2 n_rst = 1'b1;
    do_cycle(1'b0, 1'b0, 8'h00, 1'b0);
    do_cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_val("post_reset_rd", 32'(tx_packet_data), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
